// File: rtl/axi_ctrl_pkg.sv
// Shared types and constants for the AXI write-channel burst sequencer.
package axi_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/axi_w_beat_reg.sv
// One-entry W channel holding register: accepts client beats, presents them on W
// and flags the beat whose index equals the burst length as wlast.
module axi_w_beat_reg
  import axi_ctrl_pkg::*;
(
  input  logic                aclk,
  input  logic                arstn,
  input  logic                i_active,
  input  logic [LEN_W-1:0]    i_len,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_strb,
  output logic                o_wvalid,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic                o_wlast,
  input  logic                i_wready,
  output logic                o_last_hs
);

  // One bit wider than the length so a 16-beat burst can count past 15.
  logic [LEN_W:0]        r_loaded_cnt;
  logic                  r_wvalid;
  logic                  r_wlast;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  w_load;
  logic                  w_hs;

  assign w_hs       = r_wvalid && i_wready;
  assign o_wr_ready = i_active && (!r_wvalid || i_wready) && (r_loaded_cnt <= {1'b0, i_len});
  assign w_load     = o_wr_ready && i_wr_valid;
  assign o_last_hs  = w_hs && r_wlast;

  assign o_wvalid = r_wvalid;
  assign o_wdata  = r_wdata;
  assign o_wstrb  = r_wstrb;
  assign o_wlast  = r_wlast;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_loaded_cnt <= '0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      if (w_load) begin
        r_wvalid <= 1'b1;
        r_wdata  <= i_wr_data;
        r_wstrb  <= i_wr_strb;
        r_wlast  <= (r_loaded_cnt == {1'b0, i_len});
      end else if (w_hs) begin
        r_wvalid <= 1'b0;
        r_wlast  <= 1'b0;
      end
      if (!i_active)
        r_loaded_cnt <= '0;
      else if (w_load)
        r_loaded_cnt <= r_loaded_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// AXI write burst sequencer: one command in flight, AW then W beats then B.
// Optional B-phase watchdog is enabled by defining AXI_WR_TIMEOUT_EN.
module axi_wr_burst_ctrl
  import axi_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                aclk,
  input  logic                arstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                awvalid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [ID_W-1:0]     awid,
  input  logic                awready,
  output logic                wvalid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic [ID_W-1:0]     wid,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  input  logic [ID_W-1:0]     bid,
  output logic                bready,
  output logic                done_valid,
  output logic [1:0]          done_resp,
  output logic                done_id_err
);

  wr_state_e           r_state;
  wr_state_e           w_next;
  logic                r_cmd_ready;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [ID_W-1:0]     r_id;
  logic                r_done_valid;
  logic [1:0]          r_done_resp;
  logic                r_done_id_err;
  logic                w_cmd_hs;
  logic                w_b_hs;
  logic                w_timeout;
  logic                w_last_hs;
  logic                w_awvalid;
  logic                w_bready;
  logic                w_data_active;

  assign w_cmd_hs = cmd_valid && r_cmd_ready;
  assign w_b_hs   = (r_state == RESP) && bvalid;

`ifdef AXI_WR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn)
      r_to_cnt <= '0;
    else if (r_state != RESP)
      r_to_cnt <= '0;
    else if (!bvalid)
      r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Expire in the cycle whose increment would make the count reach the limit.
  assign w_timeout = (r_state == RESP) && !bvalid && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    w_awvalid     = 1'b0;
    w_bready      = 1'b0;
    w_data_active = 1'b0;
    case (r_state)
      IDLE: if (w_cmd_hs) w_next = ADDR;
      ADDR: begin
        w_awvalid = 1'b1;
        if (awready) w_next = DATA;
      end
      DATA: begin
        w_data_active = 1'b1;
        if (w_last_hs) w_next = RESP;
      end
      RESP: begin
        w_bready = 1'b1;
        if (w_b_hs || w_timeout) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_id          <= '0;
      r_done_valid  <= 1'b0;
      r_done_resp   <= '0;
      r_done_id_err <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cmd_ready  <= (w_next == IDLE);
      r_done_valid <= w_b_hs || w_timeout;
      if (w_cmd_hs) begin
        r_addr  <= cmd_addr;
        r_len   <= cmd_len;
        r_size  <= cmd_size;
        r_burst <= cmd_burst;
        r_id    <= cmd_id;
      end
      if (w_b_hs) begin
        r_done_resp   <= bresp;
        r_done_id_err <= (bid != r_id);
      end else if (w_timeout) begin
        r_done_resp   <= RESP_TIMEOUT;
        r_done_id_err <= 1'b0;
      end
    end
  end

  axi_w_beat_reg u_w_beat (
    .aclk       (aclk),
    .arstn      (arstn),
    .i_active   (w_data_active),
    .i_len      (r_len),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_wr_data  (wr_data),
    .i_wr_strb  (wr_strb),
    .o_wvalid   (wvalid),
    .o_wdata    (wdata),
    .o_wstrb    (wstrb),
    .o_wlast    (wlast),
    .i_wready   (wready),
    .o_last_hs  (w_last_hs)
  );

  assign cmd_ready   = r_cmd_ready;
  assign awvalid     = w_awvalid;
  assign awaddr      = r_addr;
  assign awlen       = r_len;
  assign awsize      = r_size;
  assign awburst     = r_burst;
  assign awid        = r_id;
  assign wid         = r_id;
  assign bready      = w_bready;
  assign done_valid  = r_done_valid;
  assign done_resp   = r_done_resp;
  assign done_id_err = r_done_id_err;

endmodule
